rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter_if.sv | 18 +
 rtl/rf_wb_arbiter.sv | 91 +++++++++
 tb/tb_rf_wb_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Writeback requester bus: one requester's request, destination, data and grant.
//   req   : write request, held with waddr/wdata until gnt is seen at a rising edge
//   waddr : destination register index
//   wdata : value to write
//   gnt   : combinational grant, same cycle as req
// master = requester side, slave = arbiter side.
interface rf_wb_arbiter_if #(
  parameter int unsigned DSIZE = 16,
  parameter int unsigned RSIZE = 4
) ();
  logic             req;
  logic [RSIZE-1:0] waddr;
  logic [DSIZE-1:0] wdata;
  logic             gnt;

  modport master (output req, output waddr, output wdata, input gnt);
  modport slave  (input req, input waddr, input wdata, output gnt);
endinterface

// File: rtl/rf_wb_arbiter.sv
// Two-requester round-robin arbiter for the single register-file write port.
//   i_clock    : clock, all state updates on rising edge
//   i_reset    : synchronous active-high reset
//   i_hold     : pipeline freeze, suppresses all grants
//   i_wb0/1    : requester buses (0 = ALU path, 1 = memory-load path)
//   o_rf_wen   : registered write enable to register file
//   o_rf_waddr : registered write address
//   o_rf_wdata : registered write data
//   o_ptr      : round-robin pointer, index of preferred requester
//   o_drop     : registered pulse, a granted write to register 0 was discarded
module rf_wb_arbiter #(
  parameter int unsigned DSIZE = 16,
  parameter int unsigned RSIZE = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_hold,
  rf_wb_arbiter_if.slave    i_wb0,
  rf_wb_arbiter_if.slave    i_wb1,
  output logic              o_rf_wen,
  output logic [RSIZE-1:0]  o_rf_waddr,
  output logic [DSIZE-1:0]  o_rf_wdata,
  output logic              o_ptr,
  output logic              o_drop
);

  logic             r_ptr;
  logic             r_wen;
  logic [RSIZE-1:0] r_waddr;
  logic [DSIZE-1:0] r_wdata;
  logic             r_drop;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_any_gnt;
  logic [RSIZE-1:0] w_sel_addr;
  logic [DSIZE-1:0] w_sel_data;

  // Grant decode: lone requester wins, contention resolved by r_ptr.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!i_reset && !i_hold) begin
      if (i_wb0.req && (!i_wb1.req || !r_ptr)) begin
        w_gnt0 = 1'b1;
      end else if (i_wb1.req) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  assign w_any_gnt  = w_gnt0 | w_gnt1;
  assign w_sel_addr = w_gnt1 ? i_wb1.waddr : i_wb0.waddr;
  assign w_sel_data = w_gnt1 ? i_wb1.wdata : i_wb0.wdata;

  assign i_wb0.gnt = w_gnt0;
  assign i_wb1.gnt = w_gnt1;

  // Register-file write stage and pointer; writes to register 0 are dropped.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ptr   <= 1'b0;
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_drop  <= 1'b0;
    end else if (w_any_gnt) begin
      // Loser of this grant becomes preferred next time.
      r_ptr <= w_gnt0;
      if (w_sel_addr != '0) begin
        r_wen   <= 1'b1;
        r_waddr <= w_sel_addr;
        r_wdata <= w_sel_data;
        r_drop  <= 1'b0;
      end else begin
        r_wen  <= 1'b0;
        r_drop <= 1'b1;
      end
    end else begin
      r_wen  <= 1'b0;
      r_drop <= 1'b0;
    end
  end

  assign o_rf_wen   = r_wen;
  assign o_rf_waddr = r_waddr;
  assign o_rf_wdata = r_wdata;
  assign o_ptr      = r_ptr;
  assign o_drop     = r_drop;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: hand-computed expectations per step.
module tb_rf_wb_arbiter;
  localparam int unsigned DSIZE = 16;
  localparam int unsigned RSIZE = 4;

  logic             clk;
  logic             reset;
  logic             hold;
  logic             rf_wen;
  logic [RSIZE-1:0] rf_waddr;
  logic [DSIZE-1:0] rf_wdata;
  logic             ptr;
  logic             drop;

  int checks   = 0;
  int failures = 0;

  rf_wb_arbiter_if #(.DSIZE(DSIZE), .RSIZE(RSIZE)) wb0 ();
  rf_wb_arbiter_if #(.DSIZE(DSIZE), .RSIZE(RSIZE)) wb1 ();

  rf_wb_arbiter #(.DSIZE(DSIZE), .RSIZE(RSIZE)) dut (
    .i_clock    (clk),
    .i_reset    (reset),
    .i_hold     (hold),
    .i_wb0      (wb0),
    .i_wb1      (wb1),
    .o_rf_wen   (rf_wen),
    .o_rf_waddr (rf_waddr),
    .o_rf_wdata (rf_wdata),
    .o_ptr      (ptr),
    .o_drop     (drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic g0, input logic g1);
    #1;
    chk({tag, "_gnt0"}, 32'(wb0.gnt), 32'(g0));
    chk({tag, "_gnt1"}, 32'(wb1.gnt), 32'(g1));
  endtask

  task automatic chk_rf(input string tag, input logic wen, input logic [RSIZE-1:0] addr,
                        input logic [DSIZE-1:0] data, input logic p, input logic d);
    chk({tag, "_wen"},   32'(rf_wen),   32'(wen));
    chk({tag, "_waddr"}, 32'(rf_waddr), 32'(addr));
    chk({tag, "_wdata"}, 32'(rf_wdata), 32'(data));
    chk({tag, "_ptr"},   32'(ptr),      32'(p));
    chk({tag, "_drop"},  32'(drop),     32'(d));
  endtask

  initial begin
    logic exp_g1;

    // Reset with both requesting: no grants, everything cleared.
    reset = 1'b1; hold = 1'b0;
    wb0.req = 1'b1; wb0.waddr = 4'd0; wb0.wdata = 16'h0000;
    wb1.req = 1'b1; wb1.waddr = 4'd0; wb1.wdata = 16'h0000;
    chk_gnt("rst", 1'b0, 1'b0);
    tick();
    chk_rf("rst", 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);

    // Single request from 0.
    reset = 1'b0; wb1.req = 1'b0;
    wb0.req = 1'b1; wb0.waddr = 4'd3; wb0.wdata = 16'h00AA;
    chk_gnt("single0", 1'b1, 1'b0);
    tick();
    chk_rf("single0", 1'b1, 4'd3, 16'h00AA, 1'b1, 1'b0);

    // Requester 1 writes register 0: dropped, RF addr/data held.
    wb0.req = 1'b0;
    wb1.req = 1'b1; wb1.waddr = 4'd0; wb1.wdata = 16'hFFFF;
    chk_gnt("r0drop", 1'b0, 1'b1);
    tick();
    chk_rf("r0drop", 1'b0, 4'd3, 16'h00AA, 1'b0, 1'b1);

    // Contention for 4 cycles alternates 0,1,0,1.
    wb0.req = 1'b1; wb0.waddr = 4'd1; wb0.wdata = 16'h0101;
    wb1.req = 1'b1; wb1.waddr = 4'd2; wb1.wdata = 16'h0202;
    for (int i = 0; i < 4; i++) begin
      exp_g1 = (i % 2) == 1;
      chk_gnt("rr", ~exp_g1, exp_g1);
      chk("rr_onehot", 32'(wb0.gnt & wb1.gnt), 32'd0);
      tick();
      chk_rf("rr", 1'b1, exp_g1 ? 4'd2 : 4'd1, exp_g1 ? 16'h0202 : 16'h0101,
             ~exp_g1, 1'b0);
    end

    // Move pointer to 1, then hold with both requesting.
    wb1.req = 1'b0; wb0.waddr = 4'd4; wb0.wdata = 16'h0444;
    chk_gnt("prehold", 1'b1, 1'b0);
    tick();
    chk_rf("prehold", 1'b1, 4'd4, 16'h0444, 1'b1, 1'b0);
    wb1.req = 1'b1; hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_gnt("hold", 1'b0, 1'b0);
      tick();
      chk_rf("hold", 1'b0, 4'd4, 16'h0444, 1'b1, 1'b0);
    end
    hold = 1'b0;
    chk_gnt("unhold", 1'b0, 1'b1);
    tick();
    chk_rf("unhold", 1'b1, 4'd2, 16'h0202, 1'b0, 1'b0);

    // Same address from both: 0 first, loser 1 next, its value lands last.
    wb0.waddr = 4'd5; wb0.wdata = 16'h1111;
    wb1.waddr = 4'd5; wb1.wdata = 16'h2222;
    chk_gnt("same_a", 1'b1, 1'b0);
    tick();
    chk_rf("same_a", 1'b1, 4'd5, 16'h1111, 1'b1, 1'b0);
    wb0.req = 1'b0;
    chk_gnt("same_b", 1'b0, 1'b1);
    tick();
    chk_rf("same_b", 1'b1, 4'd5, 16'h2222, 1'b0, 1'b0);

    // Reset mid-burst discards the in-flight request.
    wb1.req = 1'b0;
    wb0.req = 1'b1; wb0.waddr = 4'd7; wb0.wdata = 16'h0777;
    chk_gnt("burst", 1'b1, 1'b0);
    tick();
    chk_rf("burst", 1'b1, 4'd7, 16'h0777, 1'b1, 1'b0);
    reset = 1'b1;
    chk_gnt("midrst", 1'b0, 1'b0);
    tick();
    chk_rf("midrst", 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);

    // First cycle out of reset with both requesting: requester 0 wins.
    reset = 1'b0;
    wb0.req = 1'b1; wb0.waddr = 4'd1; wb0.wdata = 16'h0101;
    wb1.req = 1'b1; wb1.waddr = 4'd2; wb1.wdata = 16'h0202;
    chk_gnt("postrst", 1'b1, 1'b0);
    tick();
    chk_rf("postrst", 1'b1, 4'd1, 16'h0101, 1'b1, 1'b0);

    // Requester 0 writes register 0, then idle clears the drop pulse.
    wb1.req = 1'b0; wb0.waddr = 4'd0; wb0.wdata = 16'h5555;
    chk_gnt("drop0", 1'b1, 1'b0);
    tick();
    chk_rf("drop0", 1'b0, 4'd1, 16'h0101, 1'b1, 1'b1);
    wb0.req = 1'b0;
    chk_gnt("idle", 1'b0, 1'b0);
    tick();
    chk_rf("idle", 1'b0, 4'd1, 16'h0101, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
